dmem_bus_bridge: RTL and testbench

Sits directly downstream of the data-memory controller. It takes that controller's word-aligned memory request (address, write data, byte strobes) and runs it as a transaction on a valid/ready request/response data bus. The core is stalled until the response returns. Read data, or an access fault, is delivered to the core in the single cycle the stall drops. A response timeout and orphan-response draining protect the core from a hung or late slave.

---
 rtl/dmem_bus_bridge.sv | 134 +++++++++++++
 tb/tb_dmem_bus_bridge.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// Bridges the data-memory controller's word-aligned request onto a valid/ready
// request/response bus, stalling the core until the response (or a timeout) returns.
module dmem_bus_bridge #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_wstrb,
    output logic        bus_req_write,
    input  logic        bus_resp_valid,
    output logic        bus_resp_ready,
    input  logic [31:0] bus_resp_rdata,
    input  logic        bus_resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e               state_q, state_d;
    logic                 orphan_q, orphan_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 fault_q, fault_d;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            orphan_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            orphan_q <= orphan_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        orphan_d = orphan_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_req && !orphan_q) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                // A response in the timeout cycle takes priority over the fault
                if (bus_resp_valid) begin
                    rdata_d = bus_resp_rdata;
                    fault_d = bus_resp_err;
                    state_d = ST_DONE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    rdata_d  = '0;
                    fault_d  = 1'b1;
                    orphan_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Swallow the late response belonging to a timed-out transaction
        if (orphan_q && bus_resp_valid && (state_q != ST_RESP)) begin
            orphan_d = 1'b0;
        end
    end

    assign mem_stall      = mem_req && (state_q != ST_DONE) && !reset;
    assign mem_rdata      = rdata_q;
    assign mem_fault      = fault_q && (state_q == ST_DONE);
    assign bus_req_valid  = (state_q == ST_ADDR);
    assign bus_req_addr   = addr_q;
    assign bus_req_wdata  = wdata_q;
    assign bus_req_wstrb  = wstrb_q;
    assign bus_req_write  = |wstrb_q;
    assign bus_resp_ready = (state_q == ST_RESP) || orphan_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Directed self-checking bench for dmem_bus_bridge, built with TIMEOUT=4.
module tb_dmem_bus_bridge;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_fault;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic [31:0] bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_req_write;
    logic        bus_resp_valid;
    logic        bus_resp_ready;
    logic [31:0] bus_resp_rdata;
    logic        bus_resp_err;

    int errors = 0;
    int checks = 0;

    dmem_bus_bridge #(
        .TIMEOUT   (4),
        .TIMEOUT_W (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_rdata      (mem_rdata),
        .mem_stall      (mem_stall),
        .mem_fault      (mem_fault),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_req_addr   (bus_req_addr),
        .bus_req_wdata  (bus_req_wdata),
        .bus_req_wstrb  (bus_req_wstrb),
        .bus_req_write  (bus_req_write),
        .bus_resp_valid (bus_resp_valid),
        .bus_resp_ready (bus_resp_ready),
        .bus_resp_rdata (bus_resp_rdata),
        .bus_resp_err   (bus_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; then inputs are driven and outputs settle with #1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        mem_req        = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        mem_wstrb      = '0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_rdata = '0;
        bus_resp_err   = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_req_valid", 32'(bus_req_valid), 32'd0);
        chk("rst_resp_ready", 32'(bus_resp_ready), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        reset = 1'b0;

        // Load with zero-wait slave
        tick();
        mem_req = 1'b1; mem_addr = 32'h100; mem_wdata = '0; mem_wstrb = 4'b0000;
        bus_req_ready = 1'b1;
        #1;
        chk("ld_idle_stall", 32'(mem_stall), 32'd1);
        chk("ld_idle_valid", 32'(bus_req_valid), 32'd0);
        tick();
        chk("ld_addr_stall", 32'(mem_stall), 32'd1);
        chk("ld_addr_valid", 32'(bus_req_valid), 32'd1);
        chk("ld_addr_addr", bus_req_addr, 32'h100);
        chk("ld_addr_write", 32'(bus_req_write), 32'd0);
        tick();
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'hDEADBEEF; bus_resp_err = 1'b0;
        #1;
        chk("ld_resp_stall", 32'(mem_stall), 32'd1);
        chk("ld_resp_ready", 32'(bus_resp_ready), 32'd1);
        tick();
        bus_resp_valid = 1'b0;
        #1;
        chk("ld_done_stall", 32'(mem_stall), 32'd0);
        chk("ld_done_rdata", mem_rdata, 32'hDEADBEEF);
        chk("ld_done_fault", 32'(mem_fault), 32'd0);
        mem_req = 1'b0;
        tick();
        chk("ld_after_stall", 32'(mem_stall), 32'd0);

        // Store with request backpressure
        mem_req = 1'b1; mem_addr = 32'h204; mem_wdata = 32'h0000AB00; mem_wstrb = 4'b0010;
        bus_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("st_bp_valid", 32'(bus_req_valid), 32'd1);
            chk("st_bp_addr", bus_req_addr, 32'h204);
            chk("st_bp_wdata", bus_req_wdata, 32'h0000AB00);
            chk("st_bp_wstrb", 32'(bus_req_wstrb), 32'h2);
            chk("st_bp_stall", 32'(mem_stall), 32'd1);
            tick();
        end
        bus_req_ready = 1'b1;
        #1;
        chk("st_hs_valid", 32'(bus_req_valid), 32'd1);
        chk("st_hs_write", 32'(bus_req_write), 32'd1);
        tick();
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h12345678; bus_resp_err = 1'b0;
        #1;
        chk("st_resp_stall", 32'(mem_stall), 32'd1);
        chk("st_resp_valid", 32'(bus_req_valid), 32'd0);
        tick();
        bus_resp_valid = 1'b0;
        #1;
        chk("st_done_stall", 32'(mem_stall), 32'd0);
        chk("st_done_fault", 32'(mem_fault), 32'd0);
        mem_req = 1'b0;
        tick();

        // Slave error response
        mem_req = 1'b1; mem_addr = 32'h300; mem_wdata = '0; mem_wstrb = 4'b0000;
        bus_req_ready = 1'b1;
        tick();
        tick();
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h0; bus_resp_err = 1'b1;
        tick();
        bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
        #1;
        chk("err_done_fault", 32'(mem_fault), 32'd1);
        chk("err_done_stall", 32'(mem_stall), 32'd0);
        mem_req = 1'b0;
        tick();
        chk("err_next_fault", 32'(mem_fault), 32'd0);

        // Timeout then orphan drain
        mem_req = 1'b1; mem_addr = 32'h400; mem_wstrb = 4'b0000;
        bus_req_ready = 1'b1;
        tick();
        tick();
        bus_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_resp_stall", 32'(mem_stall), 32'd1);
            chk("to_resp_ready", 32'(bus_resp_ready), 32'd1);
            tick();
        end
        chk("to_done_fault", 32'(mem_fault), 32'd1);
        chk("to_done_stall", 32'(mem_stall), 32'd0);
        chk("to_done_rdata", mem_rdata, 32'd0);
        chk("to_done_orphan_ready", 32'(bus_resp_ready), 32'd1);
        mem_addr = 32'h500;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("orph_wait_stall", 32'(mem_stall), 32'd1);
            chk("orph_wait_valid", 32'(bus_req_valid), 32'd0);
            chk("orph_wait_ready", 32'(bus_resp_ready), 32'd1);
            tick();
        end
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'hBAD0BAD0;
        tick();
        bus_resp_valid = 1'b0;
        #1;
        chk("orph_clr_ready", 32'(bus_resp_ready), 32'd0);
        chk("orph_clr_valid", 32'(bus_req_valid), 32'd0);
        chk("orph_clr_stall", 32'(mem_stall), 32'd1);
        bus_req_ready = 1'b1;
        tick();
        chk("orph_new_valid", 32'(bus_req_valid), 32'd1);
        chk("orph_new_addr", bus_req_addr, 32'h500);
        tick();
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'hCAFEF00D;
        tick();
        bus_resp_valid = 1'b0;
        #1;
        chk("orph_new_rdata", mem_rdata, 32'hCAFEF00D);
        chk("orph_new_fault", 32'(mem_fault), 32'd0);
        chk("orph_new_stall", 32'(mem_stall), 32'd0);
        mem_req = 1'b0;
        tick();

        // Response in the same cycle the timeout would fire
        mem_req = 1'b1; mem_addr = 32'h600;
        bus_req_ready = 1'b1;
        tick();
        tick();
        bus_req_ready = 1'b0;
        tick();
        tick();
        tick();
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h600D600D;
        tick();
        bus_resp_valid = 1'b0;
        #1;
        chk("tie_rdata", mem_rdata, 32'h600D600D);
        chk("tie_fault", 32'(mem_fault), 32'd0);
        chk("tie_stall", 32'(mem_stall), 32'd0);
        chk("tie_no_orphan", 32'(bus_resp_ready), 32'd0);

        // Next request goes straight to ADDR (no orphan); then async reset in RESP
        mem_addr = 32'h700; mem_wdata = 32'h11223344; mem_wstrb = 4'b1111;
        bus_req_ready = 1'b1;
        tick();
        tick();
        chk("rr_addr_valid", 32'(bus_req_valid), 32'd1);
        tick();
        bus_req_ready = 1'b0;
        #1;
        chk("rr_resp_ready", 32'(bus_resp_ready), 32'd1);
        reset = 1'b1;
        #1;
        chk("rr_stall", 32'(mem_stall), 32'd0);
        chk("rr_req_valid", 32'(bus_req_valid), 32'd0);
        chk("rr_resp_ready0", 32'(bus_resp_ready), 32'd0);
        chk("rr_req_addr", bus_req_addr, 32'd0);
        chk("rr_req_wdata", bus_req_wdata, 32'd0);
        chk("rr_req_wstrb", 32'(bus_req_wstrb), 32'd0);
        chk("rr_req_write", 32'(bus_req_write), 32'd0);
        chk("rr_rdata", mem_rdata, 32'd0);
        chk("rr_fault", 32'(mem_fault), 32'd0);
        mem_req = 1'b0; mem_wstrb = 4'b0000; mem_wdata = '0;
        tick();
        reset = 1'b0;

        // Load after reset
        tick();
        mem_req = 1'b1; mem_addr = 32'h800;
        bus_req_ready = 1'b1;
        tick();
        chk("post_addr_valid", 32'(bus_req_valid), 32'd1);
        chk("post_addr_addr", bus_req_addr, 32'h800);
        tick();
        bus_req_ready = 1'b0;
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h0BADCAFE;
        tick();
        bus_resp_valid = 1'b0;
        #1;
        chk("post_done_rdata", mem_rdata, 32'h0BADCAFE);
        chk("post_done_stall", 32'(mem_stall), 32'd0);
        chk("post_done_fault", 32'(mem_fault), 32'd0);
        mem_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
